uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
// Shares one UART transmitter core among NUM_REQ byte-stream requesters.
// Arbitration is round-robin at packet granularity: a winner keeps the transmitter until it sends a byte
// flagged last, hits MAX_BURST bytes, or idles past HOLD_TIMEOUT.
// Sits between the requesters (e.g. the RX echo path and status reporters) and the TX serializer.
// PARAMETERS
// NUM_REQ       4     number of requesters, 2..8
// MAX_BURST     16    max bytes per grant before a forced re-arbitration, 1..255
// HOLD_TIMEOUT  64    cycles a locked grant waits for the owner's next byte, 1..65535
// DONE_TIMEOUT  65535 cycles to wait for tx_done before aborting the byte, 1..65535
// PORTS
// clk           in   1          system clock
// rst           in   1          asynchronous reset, active high
// req_valid     in   NUM_REQ    per-requester byte valid
// req_data      in   8*NUM_REQ  byte for requester i at [8*i+7:8*i]
// req_last      in   NUM_REQ    byte is the final byte of its packet
// req_ready     out  NUM_REQ    one-hot accept strobe; a transfer occurs when valid&ready
// tx_start      out  1          one-cycle pulse: tx_data is valid, begin the frame
// tx_data       out  8          byte to serialize, held stable until tx_done
// tx_done       in   1          one-cycle pulse from the TX core at the end of the stop bit
// grant_id      out  3          index of the current or last owner
// grant_active  out  1          high from ACCEPT through the end of the grant
// err_timeout   out  1          one-cycle pulse when DONE_TIMEOUT expires
// BEHAVIOUR
// Reset (async, any state): state=IDLE, all outputs 0, rr_ptr=NUM_REQ-1 so requester 0 has first priority.
// Reset also clears burst_cnt and the timers. An in-flight byte is abandoned; the TX core is reset separately.
// States: IDLE, ACCEPT, START, WAIT_DONE, HOLD.
// IDLE:
// - if any req_valid, winner = first set bit scanning rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ).
// - grant_id<=winner, burst_cnt<=0, go to ACCEPT. Otherwise stay.
// ACCEPT:
// - req_ready[grant_id]=1 (Moore output; all other bits are 0).
// - Requesters must hold req_valid high until they see ready.
// - on valid: tx_data<=byte, last_q<=req_last, burst_cnt++, go to START.
// - on valid low: go to IDLE. rr_ptr is unchanged; this happens only when a lost valid breaks protocol.
// START: tx_start=1 for exactly this cycle, then go to WAIT_DONE. Latency from valid in IDLE to tx_start is 2 cycles.
// WAIT_DONE: count cycles.
// - on tx_done: if last_q or burst_cnt==MAX_BURST, release. Otherwise, if req_valid[grant_id], go to ACCEPT; else go to HOLD.
// - if the counter reaches DONE_TIMEOUT first: pulse err_timeout and release.
// - tx_done in the same cycle as expiry counts as done: no error pulse.
// HOLD: wait for req_valid[grant_id], then go to ACCEPT. Other requesters are ignored.
// - after HOLD_TIMEOUT cycles: release.
// Release:
// - rr_ptr<=grant_id, grant_active<=0, go to IDLE; the next arbitration happens in the following cycle.
// - the released owner has lowest priority in the next round.
// grant_active=1 in ACCEPT, START, WAIT_DONE and HOLD, else 0.
// grant_id keeps its value after release.
// burst_cnt is 8 bits and saturates at MAX_BURST (compare is ==).
// Timers are 16 bits and are cleared on every state entry.
// tx_start never asserts outside START. At most one byte is in flight.
// TESTING
// 1. Reset, req_valid=0001, byte 0x55, last=1.
//    -> ready[0] at cycle+1, tx_start with tx_data=0x55 at +2; after tx_done, grant_active=0.
// 2. req_valid=1111, all last=1, continuous.
//    -> grant order 0,1,2,3,0; each gets exactly one byte per round.
// 3. Req1 sends a 3-byte packet 0x5A,0x97,0xAA (last on 0xAA) while req2 is valid.
//    -> all 3 bytes are sent back-to-back before req2 is granted.
// 4. Req0 sends 20 bytes with no last, MAX_BURST=16, req3 is valid.
//    -> grant moves to req3 after the 16th tx_done; req0 resumes next round.
// 5. Locked owner drops valid for HOLD_TIMEOUT+1 cycles.
//    -> release and req2 is granted; owner returning at HOLD_TIMEOUT-1 keeps the grant.
// 6. No tx_done for DONE_TIMEOUT cycles.
//    -> one err_timeout pulse, IDLE.
//    Also: rst asserted in WAIT_DONE -> all outputs 0 immediately.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX core among NUM_REQ byte-stream requesters.
// A grant is held per packet: until a byte flagged last, MAX_BURST bytes, or the owner idles out.
//
// state     | meaning
// IDLE      | no owner; arbitrate among valid requesters
// ACCEPT    | req_ready to the owner; capture its byte
// START     | one-cycle tx_start pulse to the TX core
// WAIT_DONE | byte in flight; wait for tx_done or DONE_TIMEOUT
// HOLD      | owner locked; wait for its next byte or HOLD_TIMEOUT
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int HOLD_TIMEOUT = 64,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic [2:0]             grant_id,
  output logic                   grant_active,
  output logic                   err_timeout
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_TIMEOUT - 1);
  localparam logic [15:0] DONE_LAST = 16'(DONE_TIMEOUT - 1);
  localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_START,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        last_q, last_d;
  logic [15:0] timer_q, timer_d;

  logic [IDW-1:0] gid;
  logic [2:0]     winner;
  logic           any_valid;

  assign gid = grant_id_q[IDW-1:0];

  // First valid requester after rr_ptr; the previous owner is scanned last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_valid && req_valid[IDW'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        winner    = 3'((int'(rr_ptr_q) + k) % NUM_REQ);
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= 3'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      tx_data_q   <= '0;
      last_q      <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
    end
  end

  // Timers default to zero so every state entry starts a fresh count.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    timer_d     = '0;
    err_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          grant_id_d  = winner;
          burst_cnt_d = '0;
          state_d     = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (req_valid[gid]) begin
          tx_data_d = req_data[{gid, 3'b000} +: 8];
          last_d    = req_last[gid];
          if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_cnt_q + 8'd1;
          state_d   = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // tx_done wins over a coincident expiry.
        if (tx_done) begin
          if (last_q || (burst_cnt_q == BURST_MAX)) begin
            rr_ptr_d = grant_id_q;
            state_d  = S_IDLE;
          end else if (req_valid[gid]) begin
            state_d = S_ACCEPT;
          end else begin
            state_d = S_HOLD;
          end
        end else if (timer_q == DONE_LAST) begin
          err_timeout = 1'b1;
          rr_ptr_d    = grant_id_q;
          state_d     = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (req_valid[gid]) begin
          state_d = S_ACCEPT;
        end else if (timer_q == HOLD_LAST) begin
          rr_ptr_d = grant_id_q;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state_q == S_ACCEPT) req_ready[gid] = 1'b1;
  end

  assign tx_start     = (state_q == S_START);
  assign grant_active = (state_q != S_IDLE);
  assign tx_data      = tx_data_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: arbitration order, packet lock, burst limit, hold and done timeouts.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int NUM_REQ      = 4;
  localparam int MAX_BURST    = 16;
  localparam int HOLD_TIMEOUT = 8;
  localparam int DONE_TIMEOUT = 20;
  localparam int TX_LAT       = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_done;
  logic [2:0]           grant_id;
  logic                 grant_active;
  logic                 err_timeout;

  uart_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST),
    .HOLD_TIMEOUT(HOLD_TIMEOUT), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_done(tx_done), .grant_id(grant_id),
    .grant_active(grant_active), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic l; } ent_t;
  ent_t       rq [NUM_REQ][$];
  int         gid_log[$];
  logic [7:0] dat_log[$];

  int n_chk, n_pass, n_fail;
  logic [NUM_REQ-1:0] xfer;
  int tx_cnt;
  bit done_en;
  int s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    ent_t e;
    e.d = d;
    e.l = l;
    rq[r].push_back(e);
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq[i][0].d;
        req_last[i]        = rq[i][0].l;
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // One clock: transfers happen at posedge, bench acts at the following negedge.
  task automatic cyc();
    xfer = req_valid & req_ready;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++)
      if (xfer[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    drive();
    if (tx_done) tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0 && done_en) tx_done = 1'b1;
    end
    if (tx_start) begin
      tx_cnt = TX_LAT;
      gid_log.push_back(int'(grant_id));
      dat_log.push_back(tx_data);
    end
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (!tx_start && k < 60) begin cyc(); k++; end
    chk({tag, "_start_seen"}, tx_start, 1);
  endtask

  task automatic wait_log(input string tag, input int n);
    int k = 0;
    while (gid_log.size() < n && k < 600) begin cyc(); k++; end
    chk({tag, "_log_count"}, gid_log.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (grant_active && k < 200) begin cyc(); k++; end
    chk({tag, "_idle"}, grant_active, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
    drive();
    tx_done = 1'b0;
    tx_cnt  = 0;
    done_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    gid_log.delete();
    dat_log.delete();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; tx_done = 1'b0; tx_cnt = 0; done_en = 1'b1;
    req_valid = '0; req_data = '0; req_last = '0;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_grant_active", grant_active, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;

    // single byte from requester 0
    push(0, 8'h55, 1'b1);
    drive();
    chk("t1_ready_idle", req_ready, 4'b0000);
    cyc();
    chk("t1_ready_c1", req_ready, 4'b0001);
    chk("t1_active_c1", grant_active, 1);
    chk("t1_start_c1", tx_start, 0);
    cyc();
    chk("t1_start_c2", tx_start, 1);
    chk("t1_data_c2", tx_data, 8'h55);
    chk("t1_ready_c2", req_ready, 4'b0000);
    cyc(); cyc();
    chk("t1_active_wait", grant_active, 1);
    cyc();
    chk("t1_released", grant_active, 0);
    chk("t1_grant_kept", grant_id, 0);
    chk("t1_log", gid_log.size(), 1);

    // all four valid, single-byte packets, two rounds
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      push(i, 8'h20 + 8'(i), 1'b1);
      push(i, 8'h30 + 8'(i), 1'b1);
    end
    drive();
    wait_log("t2", 8);
    wait_idle("t2");
    if (gid_log.size() >= 8)
      for (int k = 0; k < 8; k++) begin
        chk("t2_gid", gid_log[k], k % 4);
        chk("t2_data", dat_log[k], 32'h20 + 32'h10 * (k / 4) + k % 4);
      end

    // req1 3-byte packet locks out req2
    gid_log.delete(); dat_log.delete();
    push(1, 8'h5A, 1'b0); push(1, 8'h97, 1'b0); push(1, 8'hAA, 1'b1);
    push(2, 8'h77, 1'b1);
    drive();
    wait_log("t3", 4);
    wait_idle("t3");
    if (gid_log.size() >= 4) begin
      chk("t3_gid0", gid_log[0], 1); chk("t3_dat0", dat_log[0], 8'h5A);
      chk("t3_gid1", gid_log[1], 1); chk("t3_dat1", dat_log[1], 8'h97);
      chk("t3_gid2", gid_log[2], 1); chk("t3_dat2", dat_log[2], 8'hAA);
      chk("t3_gid3", gid_log[3], 2); chk("t3_dat3", dat_log[3], 8'h77);
    end

    // req0 20 bytes without last, burst limit 16, req3 waiting
    gid_log.delete(); dat_log.delete();
    for (int k = 0; k < 20; k++) push(0, 8'(k), 1'b0);
    drive();
    wait_start("t4");
    push(3, 8'hC3, 1'b1);
    drive();
    wait_log("t4", 21);
    wait_idle("t4");
    if (gid_log.size() >= 21) begin
      chk("t4_gid15", gid_log[15], 0); chk("t4_dat15", dat_log[15], 8'h0F);
      chk("t4_gid16", gid_log[16], 3); chk("t4_dat16", dat_log[16], 8'hC3);
      chk("t4_gid17", gid_log[17], 0); chk("t4_dat17", dat_log[17], 8'h10);
      chk("t4_gid20", gid_log[20], 0); chk("t4_dat20", dat_log[20], 8'h13);
    end

    // hold: return on the last hold cycle keeps grant, silence releases it
    gid_log.delete(); dat_log.delete();
    push(1, 8'h11, 1'b0);
    push(2, 8'h22, 1'b1);
    drive();
    wait_start("t5a");
    chk("t5_gid_first", grant_id, 1);
    for (s = 0; s < 3; s++) cyc();
    chk("t5_hold_active", grant_active, 1);
    chk("t5_hold_ready", req_ready, 4'b0000);
    for (s = 0; s < 7; s++) cyc();
    push(1, 8'h12, 1'b0);
    drive();
    chk("t5_hold_last_active", grant_active, 1);
    cyc();
    chk("t5_kept_ready", req_ready, 4'b0010);
    cyc();
    chk("t5_kept_start", tx_start, 1);
    chk("t5_kept_data", tx_data, 8'h12);
    for (s = 0; s < 10; s++) cyc();
    chk("t5_hold2_last", grant_active, 1);
    cyc();
    chk("t5_released", grant_active, 0);
    chk("t5_gid_kept", grant_id, 1);
    cyc();
    chk("t5_req2_ready", req_ready, 4'b0100);
    chk("t5_req2_gid", grant_id, 2);
    wait_log("t5", 3);
    wait_idle("t5");

    // done timeout with no tx_done
    done_en = 1'b0;
    push(3, 8'h66, 1'b1);
    drive();
    wait_start("t6");
    for (s = 0; s < 19; s++) cyc();
    chk("t6_err_early", err_timeout, 0);
    cyc();
    chk("t6_err_pulse", err_timeout, 1);
    chk("t6_err_active", grant_active, 1);
    chk("t6_data_held", tx_data, 8'h66);
    cyc();
    chk("t6_err_cleared", err_timeout, 0);
    chk("t6_idle", grant_active, 0);

    // tx_done coincident with expiry: no error
    push(0, 8'h67, 1'b1);
    drive();
    wait_start("t6b");
    for (s = 0; s < 20; s++) cyc();
    tx_done = 1'b1;
    #1;
    chk("t6b_no_err", err_timeout, 0);
    cyc();
    chk("t6b_idle", grant_active, 0);
    chk("t6b_no_err_after", err_timeout, 0);

    // async reset during WAIT_DONE
    done_en = 1'b1;
    push(1, 8'h99, 1'b1);
    drive();
    wait_start("t7");
    cyc();
    chk("t7_pre_active", grant_active, 1);
    chk("t7_pre_data", tx_data, 8'h99);
    rst = 1'b1;
    #1;
    chk("t7_rst_active", grant_active, 0);
    chk("t7_rst_data", tx_data, 0);
    chk("t7_rst_gid", grant_id, 0);
    chk("t7_rst_start", tx_start, 0);
    chk("t7_rst_ready", req_ready, 0);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
